// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter sharing one FTDI UART transmitter among N_REQ byte producers.
// Optional: define FTDI_ARB_LOCK_EN to add req_lock for contiguous multi-byte packets.
module ftdi_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [8*N_REQ-1:0]    req_data,
`ifdef FTDI_ARB_LOCK_EN
  input  logic [N_REQ-1:0]      req_lock,
`endif
  output logic [N_REQ-1:0]      req_ack,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_ready,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic                  busy,
  output logic                  drop
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [N_REQ-1:0]    req_ack_q, req_ack_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [ID_WIDTH-1:0] win, idx;
  logic                win_vld;
  logic [7:0]          win_byte;
  logic                grant, timeout_hit;

  // Winner search: first set req starting just after the last winner.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_WIDTH'((int'(rr_ptr_q) + k) % N_REQ);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
`ifdef FTDI_ARB_LOCK_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i) && req_lock[i] && req[i]) begin
        win_vld = 1'b1;
        win     = grant_id_q;
      end
    end
`endif
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win == ID_WIDTH'(i)) win_byte = req_data[8*i +: 8];
  end

  assign grant       = (state_q == S_IDLE) && tx_ready && win_vld;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: begin
        if (!tx_ready)        state_d = S_BUSY;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_BUSY:  if (tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < N_REQ; i++)
      req_ack_d[i] = grant && (win == ID_WIDTH'(i));
    tx_start_d = (state_q == S_ISSUE) && (state_d == S_ISSUE);
    drop_d     = (state_q == S_ISSUE) && tx_ready && timeout_hit;
    busy_d     = (state_d != S_IDLE);
    if (grant) begin
      tx_data_d  = win_byte;
      grant_id_d = win;
      rr_ptr_d   = win;
      cnt_d      = '0;
    end else if (state_q == S_ISSUE && TIMEOUT != 0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= ID_WIDTH'(N_REQ - 1);
      grant_id_q <= '0;
      req_ack_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      req_ack_q  <= req_ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Bench for ftdi_tx_arbiter: vector table, corner sequences, randomized traffic vs reference model.
module tb_ftdi_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy, drop;
`ifdef FTDI_ARB_LOCK_EN
  logic [3:0]  req_lock = '0;
`endif

  ftdi_tx_arbiter #(.N_REQ(N), .ID_WIDTH(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
`ifdef FTDI_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ack(req_ack), .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; tx_ready = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // Waits for a grant, then plays an accepting transmitter for that byte.
  task automatic serve_one(output logic [3:0] ack, output logic [7:0] b);
    logic got_start;
    ack = '0; b = '0; got_start = 1'b0;
    for (int k = 0; k < 20 && ack == 0; k++) begin
      step();
      if (req_ack != 0) begin ack = req_ack; b = tx_data; end
    end
    if (ack == 0) begin
      n_tot++; $display("FAIL serve_ack_wait: got no ack, required one within 20 cycles");
      return;
    end
    for (int k = 0; k < 20 && !got_start; k++) begin
      step();
      if (tx_start) begin got_start = 1'b1; tx_ready = 1'b0; end
    end
    if (!got_start) begin
      n_tot++; $display("FAIL serve_start_wait: got no tx_start, required one within 20 cycles");
    end
    step();
    tx_ready = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [3:0] a;
    logic [7:0] b;
    logic [3:0] exp_seq[5];
    int cnt, bad;
    logic seen;

    reset = 1'b1; req = '0; req_data = '0; tx_ready = 1'b1;
    step();
    chk("reset_outputs", {req_ack, tx_data, tx_start, grant_id, busy, drop}, '0);
    reset = 1'b0;

    // Single grant from a fresh reset: requester search starts at 0.
    tbl[0] = '{4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 8'hA5};
    tbl[1] = '{4'b1100, 32'h4433_2211, 4'b0100, 2'd2, 8'h33};
    tbl[2] = '{4'b1000, 32'h4433_2211, 4'b1000, 2'd3, 8'h44};
    tbl[3] = '{4'b0110, 32'h4433_2211, 4'b0010, 2'd1, 8'h22};
    tbl[4] = '{4'b1111, 32'h4433_2211, 4'b0001, 2'd0, 8'h11};
    tbl[5] = '{4'b0000, 32'h4433_2211, 4'b0000, 2'd0, 8'h00};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      req = tbl[v].rq; req_data = tbl[v].data; tx_ready = 1'b1;
      step();
      chk($sformatf("vec%0d_ack", v), req_ack, tbl[v].exp_ack);
      chk($sformatf("vec%0d_gid", v), grant_id, tbl[v].exp_gid);
      chk($sformatf("vec%0d_data", v), tx_data, tbl[v].exp_byte);
      chk($sformatf("vec%0d_start0", v), tx_start, 1'b0);
      req = '0;
      step();
      chk($sformatf("vec%0d_ack_pulse", v), req_ack, 4'b0000);
      chk($sformatf("vec%0d_start1", v), tx_start, tbl[v].exp_ack != 0);
      chk($sformatf("vec%0d_data_hold", v), tx_data, tbl[v].exp_byte);
    end

    // All requesting: strict rotation.
    do_reset();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111; req_data = 32'hD4C3_B2A1;
    for (int g = 0; g < 5; g++) begin
      serve_one(a, b);
      chk($sformatf("rr_grant%0d", g), a, exp_seq[g]);
    end

    // Transmitter never accepts: timeout drops the byte.
    do_reset();
    req = 4'b0001; req_data = 32'h0000_005A;
    step();
    chk("to_ack", req_ack, 4'b0001);
    req = '0; cnt = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (tx_start) cnt++;
      if (drop) begin
        seen = 1'b1;
        chk("to_start_low_at_drop", tx_start, 1'b0);
        chk("to_idle_at_drop", busy, 1'b0);
      end
    end
    chk("to_drop_seen", seen, 1'b1);
    chk("to_start_cycles", cnt, TO);
    step();
    chk("to_drop_pulse", drop, 1'b0);

    // Reset while in ISSUE, then while in BUSY.
    do_reset();
    req = 4'b0010; req_data = 32'h0000_7700;
    step();
    chk("rst_issue_ack", req_ack, 4'b0010);
    step();
    chk("rst_issue_start", tx_start, 1'b1);
    reset = 1'b1;
    step();
    chk("rst_issue_out", {tx_start, busy, drop, req_ack}, '0);
    reset = 1'b0;
    step();
    chk("rst_busy_ack", req_ack, 4'b0010);
    step();
    tx_ready = 1'b0;
    step();
    chk("rst_busy_state", {busy, tx_start}, 2'b10);
    reset = 1'b1;
    step();
    chk("rst_busy_out", {tx_start, busy, drop, req_ack}, '0);
    reset = 1'b0; tx_ready = 1'b1; req = 4'b0011;
    step();
    chk("rst_prio0", req_ack, 4'b0001);

    // tx_ready low in IDLE blocks the grant.
    do_reset();
    tx_ready = 1'b0; req = 4'b0100; req_data = 32'h0033_0000; bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (req_ack != 0) bad++;
    end
    chk("rdy_low_noack", bad, 0);
    tx_ready = 1'b1;
    step();
    chk("rdy_ack", req_ack, 4'b0100);
    chk("rdy_gid", grant_id, 2'd2);

`ifdef FTDI_ARB_LOCK_EN
    do_reset();
    req = 4'b0011; req_data = 32'h0000_2211; req_lock = 4'b0001;
    for (int g = 0; g < 3; g++) begin
      serve_one(a, b);
      chk($sformatf("lock_grant%0d", g), a, 4'b0001);
    end
    req_lock = 4'b0000;
    serve_one(a, b);
    chk("lock_release", a, 4'b0010);
    req = '0;
`endif

    // Randomized traffic against a reference: rotation order, byte integrity, timeout length.
    begin
      logic [3:0]  req_prev, rq;
      logic [31:0] data_prev;
      logic        rdy_prev;
      logic [7:0]  q[$];
      int last_w, w, start_cnt, ignore_for, busy_left, grants, sent, drops;
      do_reset();
      last_w = N - 1; start_cnt = 0; ignore_for = 0; busy_left = 0;
      grants = 0; sent = 0; drops = 0; rq = '0;
      req_data = $urandom;
      for (int c = 0; c < 3200; c++) begin
        req_prev = req; data_prev = req_data; rdy_prev = tx_ready;
        step();
        w = -1;
        if (req_ack != 0 || (rdy_prev && req_prev != 0 && !busy)) begin
          for (int k = 1; k <= N; k++)
            if (w < 0 && req_prev[(last_w + k) % N]) w = (last_w + k) % N;
        end
        if (req_ack != 0) begin
          chk("rnd_ack", req_ack, (rdy_prev && w >= 0) ? (4'b0001 << w) : 4'b0000);
          if (w >= 0) begin
            chk("rnd_gid", grant_id, w);
            chk("rnd_data", tx_data, data_prev[8*w +: 8]);
            q.push_back(tx_data);
            grants++;
            last_w = w;
            start_cnt = 0;
            ignore_for = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 3);
            rq[w] = $urandom_range(0, 1);
            req_data[8*w +: 8] = $urandom;
          end
        end
        if (tx_start) begin
          start_cnt++;
          if (tx_ready && start_cnt > ignore_for) begin
            if (q.size() == 0) begin
              n_tot++; $display("FAIL rnd_unexpected_start: got tx_start, required no byte pending");
            end else chk("rnd_byte", tx_data, q.pop_front());
            sent++;
            tx_ready = 1'b0;
            busy_left = $urandom_range(1, 4);
          end
        end else if (!tx_ready) begin
          busy_left--;
          if (busy_left <= 0) tx_ready = 1'b1;
        end
        if (drop) begin
          chk("rnd_drop_len", start_cnt, TO);
          if (q.size() != 0) void'(q.pop_front());
          drops++;
          start_cnt = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (req_ack[i]) continue;
          if (!rq[i] && c < 3000 && $urandom_range(0, 2) == 0) begin
            rq[i] = 1'b1; req_data[8*i +: 8] = $urandom;
          end else if (rq[i] && $urandom_range(0, 15) == 0) begin
            rq[i] = 1'b0;
          end
        end
        if (c >= 3000) rq = '0;
        req = rq;
      end
      chk("rnd_queue_empty", q.size(), 0);
      chk("rnd_accounting", grants, sent + drops);
      chk("rnd_activity", grants > 100, 1'b1);
      chk("rnd_drops_seen", drops > 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
